// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter sharing CHANNELS result-bus channels among REQUESTERS execution units.
// Grants, channel indices and per-channel owner addresses are all registered.
module result_bus_arbiter #(
    parameter int REQUESTERS = 5,
    parameter int CHANNELS   = 2,
    parameter int ADDR_W     = 8,
    parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int PTR_W      = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [REQUESTERS-1:0]        req,
    output logic [REQUESTERS-1:0]        grant,
    output logic [REQUESTERS*CH_W-1:0]   grant_channel,
    output logic [CHANNELS-1:0]          channel_valid,
    output logic [CHANNELS*ADDR_W-1:0]   channel_owner
);

    logic [PTR_W-1:0]             ptr_r;
    logic [REQUESTERS-1:0]        grant_r;
    logic [REQUESTERS*CH_W-1:0]   chan_r;
    logic [CHANNELS-1:0]          valid_r;
    logic [CHANNELS*ADDR_W-1:0]   owner_r;

    logic [REQUESTERS-1:0]        elig_s;
    logic [REQUESTERS-1:0]        grant_s;
    logic [REQUESTERS*CH_W-1:0]   chan_s;
    logic [CHANNELS-1:0]          valid_s;
    logic [CHANNELS*ADDR_W-1:0]   owner_s;
    logic [PTR_W-1:0]             ptr_next_s;
    logic                         take_s;
    int                           idx_s;
    int                           cnt_s;
    int                           last_s;

    // A unit granted last cycle sits out one cycle so each grant is a single pulse.
    assign elig_s = req & ~grant_r;

    // Rotating scan from ptr: the k-th eligible unit found takes channel k.
    always_comb begin
        grant_s = '0;
        chan_s  = '0;
        valid_s = '0;
        owner_s = '0;
        take_s  = 1'b0;
        idx_s   = 0;
        cnt_s   = 0;
        last_s  = int'(ptr_r);
        for (int k = 0; k < REQUESTERS; k++) begin
            idx_s  = int'(ptr_r) + k;
            take_s = 1'b0;
            if (idx_s >= REQUESTERS) begin
                idx_s = idx_s - REQUESTERS;
            end else begin
                idx_s = idx_s;
            end
            for (int r = 0; r < REQUESTERS; r++) begin
                if ((r == idx_s) && elig_s[r] && (cnt_s < CHANNELS)) begin
                    grant_s[r]             = 1'b1;
                    chan_s[r*CH_W +: CH_W] = CH_W'(cnt_s);
                    last_s                 = r;
                    take_s                 = 1'b1;
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (c == cnt_s) begin
                            valid_s[c]                   = 1'b1;
                            owner_s[c*ADDR_W +: ADDR_W]  = ADDR_W'(r + 1);
                        end else begin
                            valid_s[c] = valid_s[c];
                        end
                    end
                end else begin
                    grant_s[r] = grant_s[r];
                end
            end
            if (take_s) begin
                cnt_s = cnt_s + 1;
            end else begin
                cnt_s = cnt_s;
            end
        end
    end

    // Next priority pointer: one past the unit that took the highest channel.
    always_comb begin
        if ((last_s + 1) >= REQUESTERS) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = PTR_W'(last_s + 1);
        end
    end

    // Grant/owner registers and priority pointer; flush kills grants but keeps ptr.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_r   <= '0;
            grant_r <= '0;
            chan_r  <= '0;
            valid_r <= '0;
            owner_r <= '0;
        end else if (flush) begin
            ptr_r   <= ptr_r;
            grant_r <= '0;
            chan_r  <= '0;
            valid_r <= '0;
            owner_r <= '0;
        end else begin
            grant_r <= grant_s;
            chan_r  <= chan_s;
            valid_r <= valid_s;
            owner_r <= owner_s;
            if (|grant_s) begin
                ptr_r <= ptr_next_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    assign grant         = grant_r;
    assign grant_channel = chan_r;
    assign channel_valid = valid_r;
    assign channel_owner = owner_r;

endmodule
